sum_engine_arbiter: RTL
=======================

SUM_ENGINE_ARBITER -- requirements
Module: sum_engine_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one sum-to-N engine; range 2..8.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles in WAIT before abort; range 9..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 req  input  NREQ  bit i high: requester i has a pending job.
REQ-006 req_n  input  3*NREQ  N for requester i in bits [3i+2:3i].
REQ-007 req_ready  output  NREQ  one-hot: requester i accepted this cycle.
REQ-008 rsp_valid  output  NREQ  one-hot: result for requester i is present.
REQ-009 rsp_sum  output  5  result bus, meaningful only while any rsp_valid bit is high.
REQ-010 rsp_err  output  1  high with rsp_valid when the job was aborted by timeout.
REQ-011 rsp_ack  input  NREQ  bit i high: requester i consumes its result.
REQ-012 grant_id  output  clog2(NREQ)  index of current owner; holds last owner when idle.
REQ-013 eng_N  output  3  N to engine, driven continuously from the latched job register.
REQ-014 eng_N_valid  output  1  one-cycle launch pulse to engine.
REQ-015 eng_sum_valid  input  1  engine result-ready level.
REQ-016 eng_sum  input  5  engine result.
REQ-017 eng_ack  output  1  one-cycle release pulse to engine.

Function
REQ-018 The FSM SHALL have states IDLE, LAUNCH, WAIT, RELEASE, RETURN.
REQ-019 IDLE: if any req bit is high, arbiter SHALL pick the winner round-robin starting at pointer ptr; combinationally assert req_ready[winner]; latch req_n slice, winner into grant_id.
REQ-020 Requesters SHALL hold req and req_n stable until req_ready; req_ready SHALL be high for exactly one cycle per accepted job.
REQ-021 Accepted N != 0: IDLE -> LAUNCH; accepted N == 0: IDLE -> RETURN with result 0, engine untouched.
REQ-022 LAUNCH: eng_N_valid=1 for exactly one cycle; -> WAIT; timeout counter cleared.
REQ-023 WAIT: on eng_sum_valid=1, capture eng_sum into result register, rsp_err=0, -> RELEASE.
REQ-024 WAIT: if counter reaches TIMEOUT without eng_sum_valid, result=0, rsp_err=1, -> RETURN without eng_ack.
REQ-025 RELEASE: eng_ack=1 for exactly one cycle; -> RETURN.
REQ-026 RETURN: rsp_valid[grant_id]=1 and rsp_sum=result held until rsp_ack[grant_id]=1; that cycle -> IDLE, ptr=(grant_id+1) mod NREQ.
REQ-027 rsp_ack bits for non-owners, or outside RETURN, SHALL be ignored.
REQ-028 req bits arriving outside IDLE SHALL wait; no job is dropped or queued beyond one per requester.
REQ-029 A requester may re-request in the cycle after its rsp_ack; fairness: it is served after all other pending requesters.
REQ-030 Latency with N>=1 and immediate rsp_ack: accept to rsp_valid = engine latency + 3 cycles.
REQ-031 eng_N_valid SHALL be 0 in every state except LAUNCH, so the engine never relaunches after eng_ack.
REQ-032 Result width 5 bits; max legal value 28 (N=7); no saturation logic.

Reset
REQ-033 While reset=0: state IDLE, ptr=0, grant_id=0, latched N=0, result=0, all outputs 0, immediately and asynchronously.
REQ-034 Reset mid-job SHALL abandon the job without response; the engine SHALL be reset in the same event by the integrating top.
REQ-035 First accepted job after reset release SHALL be arbitrated from ptr=0.

Verification
REQ-036 req[0]=1, N=4 -> req_ready[0] pulse, one eng_N_valid with eng_N=4, rsp_valid[0], rsp_sum=10, rsp_err=0, one eng_ack.
REQ-037 req[0..3] all high, N=1,3,5,7 -> service order 0,1,2,3; sums 1,6,15,28; then ptr=0.
REQ-038 req[2]=1, N=0 -> rsp_valid[2], rsp_sum=0 one cycle after accept; eng_N_valid never asserted.
REQ-039 Engine model holds eng_sum_valid=0 -> after TIMEOUT=16 cycles in WAIT, rsp_err=1, rsp_sum=0, no eng_ack.
REQ-040 rsp_ack withheld 5 cycles, rsp_ack[1] pulsed while owner is 0 -> rsp_valid[0] held steady, ignored ack, return on rsp_ack[0].
REQ-041 reset=0 during WAIT -> all outputs 0 same cycle; after release, req[3] N=2 -> rsp_sum=3.

Source files
------------

// File: rtl/sum_engine_arbiter.sv
// Round-robin arbiter sharing one sum-to-N engine among NREQ requesters.
// Owns the engine launch/release handshake, a WAIT timeout and the per-requester response return.
module sum_engine_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [3*NREQ-1:0]        req_n,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [4:0]               rsp_sum,
    output logic                     rsp_err,
    input  logic [NREQ-1:0]          rsp_ack,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic [2:0]               eng_N,
    output logic                     eng_N_valid,
    input  logic                     eng_sum_valid,
    input  logic [4:0]               eng_sum,
    output logic                     eng_ack
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RETURN  = 3'd4
    } state_t;

    state_t            state_r;
    logic [IDW-1:0]    ptr_r;
    logic [IDW-1:0]    grant_id_r;
    logic [IDW-1:0]    winner_s;
    logic              found_s;
    logic [2:0]        n_sel_s;
    logic [2:0]        n_r;
    logic [4:0]        result_r;
    logic              err_r;
    logic              eng_n_valid_r;
    logic              eng_ack_r;
    logic [NREQ-1:0]   rsp_valid_r;
    logic [7:0]        cnt_r;

    function automatic logic [NREQ-1:0] one_hot(input logic [IDW-1:0] idx);
        logic [NREQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Round-robin pick: the pending requester closest at or after ptr_r wins.
    always_comb begin
        int best_rank;
        int rank;
        logic take;
        best_rank = NREQ;
        rank      = 0;
        take      = 1'b0;
        winner_s  = '0;
        n_sel_s   = 3'd0;
        found_s   = |req;
        for (int i = 0; i < NREQ; i++) begin
            rank      = (i + NREQ - int'(ptr_r)) % NREQ;
            take      = req[i] && (rank < best_rank);
            best_rank = take ? rank : best_rank;
            winner_s  = take ? IDW'(i) : winner_s;
            n_sel_s   = take ? req_n[3*i +: 3] : n_sel_s;
        end
    end

    // Gated by reset so nothing is accepted while the block is held in reset.
    assign req_ready = (state_r == ST_IDLE && found_s && reset) ? one_hot(winner_s) : '0;

    // Job FSM with registered engine handshake and response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            ptr_r         <= '0;
            grant_id_r    <= '0;
            n_r           <= 3'd0;
            result_r      <= 5'd0;
            err_r         <= 1'b0;
            rsp_valid_r   <= '0;
            eng_n_valid_r <= 1'b0;
            eng_ack_r     <= 1'b0;
            cnt_r         <= 8'd0;
        end else begin
            eng_n_valid_r <= 1'b0;
            eng_ack_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        grant_id_r <= winner_s;
                        n_r        <= n_sel_s;
                        if (n_sel_s != 3'd0) begin
                            state_r       <= ST_LAUNCH;
                            eng_n_valid_r <= 1'b1;
                        end else begin
                            // N == 0 needs no engine: answer 0 directly.
                            state_r     <= ST_RETURN;
                            result_r    <= 5'd0;
                            err_r       <= 1'b0;
                            rsp_valid_r <= one_hot(winner_s);
                        end
                    end
                end
                ST_LAUNCH: begin
                    cnt_r   <= 8'd0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_sum_valid) begin
                        result_r  <= eng_sum;
                        err_r     <= 1'b0;
                        eng_ack_r <= 1'b1;
                        state_r   <= ST_RELEASE;
                    end else if (cnt_r == 8'(TIMEOUT - 1)) begin
                        // Engine gave up on: report an error and skip the release pulse.
                        result_r    <= 5'd0;
                        err_r       <= 1'b1;
                        rsp_valid_r <= one_hot(grant_id_r);
                        state_r     <= ST_RETURN;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    rsp_valid_r <= one_hot(grant_id_r);
                    state_r     <= ST_RETURN;
                end
                ST_RETURN: begin
                    if (rsp_ack[grant_id_r]) begin
                        rsp_valid_r <= '0;
                        err_r       <= 1'b0;
                        ptr_r       <= (grant_id_r == IDW'(NREQ - 1)) ? '0 : grant_id_r + IDW'(1);
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_r;
    assign rsp_sum     = result_r;
    assign rsp_err     = err_r;
    assign grant_id    = grant_id_r;
    assign eng_N       = n_r;
    assign eng_N_valid = eng_n_valid_r;
    assign eng_ack     = eng_ack_r;

endmodule
